nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequential controller that performs WIDTH-bit add/subtract by time-multiplexing a single `ripple_4bit_carry_adder` instance over WIDTH/4 nibbles, least-significant nibble first, with a registered carry chained between cycles.
- Trades latency for area: one 4-bit adder serves arbitrarily wide operands.
- Sits between an upstream operand source and a downstream result consumer, connected by valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and ≥ 8.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand set valid.
- `in_ready` output 1: controller can accept operands.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in for add mode; ignored in subtract mode.
- `sub` input 1: 1 selects A − B; 0 selects A + B + cin.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: result.
- `cout` output 1: final carry-out. In subtract mode this is the no-borrow flag (1 when A ≥ B unsigned).
- `ovf` output 1: two's-complement overflow.
- `busy` output 1: high in RUN.

## Operation
- Instantiates exactly one `ripple_4bit_carry_adder`. Its inputs are:
  - low nibble of operand shift register A;
  - low nibble of operand shift register B_eff;
  - carry register `c_q`.
- N = WIDTH/4. Nibble counter is $clog2(N) bits wide.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
    - load A shift register ← `a`;
    - load B_eff ← (`sub` ? ~`b` : `b`);
    - `c_q` ← (`sub` ? 1 : `cin`);
    - latch `a[WIDTH-1]` and B_eff MSB as sign_a and sign_b;
    - counter ← 0;
    - go to RUN.
  - RUN: each cycle, adder output nibble is shifted into the result register from the top (result ← {nibble, result[WIDTH-1:4]}). Also:
    - `c_q` ← adder cout;
    - A and B_eff shift right by 4;
    - counter increments.
    - On the edge where counter == N−1, go to DONE.
  - DONE: `out_valid`=1. `sum` = result register; `cout` = `c_q`.
    - `ovf` = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a).
    - On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. `in_valid` in RUN or DONE is ignored and no operands are captured.
- `sum`, `cout` and `ovf` stay stable throughout DONE regardless of input activity.
- Reset (`rst_n`=0, any state, including mid-RUN) has immediate effect:
  - state ← IDLE;
  - all registers ← 0;
  - outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `ovf`=0.
  - A partially computed result is discarded.
- Outputs are registered or decoded from state only. There is no combinational path from `a`, `b`, `cin` or `sub` to any output.

## Timing
- Accept edge T0 (IDLE, `in_valid`=1). RUN occupies cycles T0+1 … T0+N. `out_valid` rises in the cycle after edge T0+N.
- Latency from accept edge to `out_valid` is N+1 edges: 5 for WIDTH=16.
- Minimum handshake-to-handshake period is N+2 cycles, which applies when `out_ready` is held 1. The next `in_ready` is seen in the cycle after the output handshake.
- `out_ready` held low keeps DONE indefinitely with no result change.
- Carry between nibbles is registered, so the adder critical path is 4 bits regardless of WIDTH.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x0FFF, cin=0, sub=0 → after 5 edges: `out_valid`=1, `sum`=0x2233, `cout`=0, `ovf`=0; `busy` high for exactly 4 cycles.
- Carry ripples through every nibble: a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0. Separately, a=0xFFFF, b=0x0000, cin=1 → `sum`=0x0000, `cout`=1.
- Subtract and signed overflow:
  - a=0x0005, b=0x0007, sub=1 → `sum`=0xFFFE, `cout`=0, `ovf`=0.
  - a=0x7FFF, b=0x0001, sub=0 → `sum`=0x8000, `ovf`=1.
  - a=0x8000, b=0x0001, sub=1 → `sum`=0x7FFF, `ovf`=1, `cout`=1.
- Backpressure and ignored inputs: hold `out_ready`=0 for 3 cycles in DONE, pulse `in_valid` with new operands during RUN and DONE → result unchanged, `in_ready`=0 throughout, new operands not captured. Then `out_ready`=1 → IDLE next cycle.
- Reset mid-operation: assert `rst_n`=0 asynchronously during the 2nd RUN cycle → `busy`, `out_valid`, `sum`, `cout` and `ovf` go to 0 without a clock edge, and `in_ready`=1. After release, a fresh 0x0001+0x0001 yields `sum`=0x0002 with no residue from the aborted operation.
- Parameter sweep: WIDTH=8 and WIDTH=32, 1000 random operand/`sub`/`cin` sets each, with random `out_ready` → every result matches a reference model, and latency is N+1 every time.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor.
// A single 4-bit ripple adder is reused over WIDTH/4 cycles, least-significant
// nibble first. The carry between nibbles is held in a register, so the
// combinational path is one 4-bit adder wide whatever WIDTH is.
// Operands come in and the result goes out over valid/ready handshakes.

// 4-bit ripple-carry adder: the only arithmetic element in the controller.
module ripple_4bit_carry_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    // One full adder per bit; each bit's carry-out feeds the next bit.
    for (genvar k = 0; k < 4; k++) begin : g_fa
        assign o_sum[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
        assign w_c[k + 1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
    end

    assign o_cout = w_c[4];

endmodule

// Controller that runs the adder over the operand nibbles.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;        // operand A, shifted right one nibble per RUN cycle
    logic [WIDTH-1:0] r_b;        // operand B after optional inversion, shifted the same way
    logic [WIDTH-1:0] r_result;   // result, filled from the top one nibble at a time
    logic             r_c;        // carry between nibbles; holds the final carry in DONE
    logic             r_sign_a;
    logic             r_sign_b;
    logic [CW-1:0]    r_cnt;

    logic [3:0]       w_nib;
    logic             w_nib_cout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == LAST_NIB);

    ripple_4bit_carry_adder u_adder (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_c),
        .o_sum  (w_nib),
        .o_cout (w_nib_cout)
    );

    // State register; reset returns to IDLE at once, even in the middle of RUN.
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // flop samples the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: accept in IDLE, run N nibbles, then hold until the consumer takes the result.
    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)  w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: capture operands on accept, then one adder nibble per RUN cycle.
    // Subtract is done as A + ~B + 1, so the carry register is seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= sub ? ~b : b;
                        r_c      <= sub ? 1'b1 : cin;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_result <= {w_nib, r_result[WIDTH-1:4]};
                    r_c      <= w_nib_cout;
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: begin
                    // DONE holds every register so the result stays stable under backpressure.
                end
            endcase
        end
    end

    assign sum  = r_result;
    assign cout = r_c;
    // Overflow: both addends have the same sign and the result sign differs.
    assign ovf  = (r_sign_a == r_sign_b) && (r_result[WIDTH-1] != r_sign_a);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl.
// Three instances run side by side: WIDTH=16 takes the directed cases, and
// WIDTH=8 and WIDTH=32 take random operands with random out_ready.
// Each instance has its own expected-result queue and its own monitor.
module tb_nibble_serial_adder_ctrl;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          acc;   // index of the edge that accepted the operands
    } exp_t;

    logic clk;
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model built from plain integer arithmetic at width w.
    function automatic void ref_model(int w, logic [31:0] ta, logic [31:0] tb, logic tc, logic ts,
                                      output logic [31:0] s, output logic co, output logic ov);
        longint m, ua, ub, sa, sb, r, full;
        m  = longint'(1) << w;
        ua = longint'(ta) & (m - 1);
        ub = longint'(tb) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (ts) begin
            full = ua - ub;
            r    = sa - sb;
            co   = (ua >= ub);
        end else begin
            full = ua + ub + longint'(tc);
            r    = sa + sb + longint'(tc);
            co   = (full >= m);
        end
        s  = 32'(full & (m - 1));
        ov = (r >= m / 2) || (r < -(m / 2));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 32;
        localparam int N = W / 4;

        logic         rst_n_l;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         busy;

        exp_t q[$];
        bit   seen = 1'b0;
        bit   r_done = 1'b0;

        nibble_serial_adder_ctrl #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_l),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf),
            .busy      (busy)
        );

        task automatic push_exp(logic [31:0] es, logic eco, logic eov);
            exp_t e;
            e.s   = es;
            e.co  = eco;
            e.ov  = eov;
            e.acc = edge_cnt + 1;
            q.push_back(e);
        endtask

        // Present one operand set, wait for in_ready, record the expected result.
        task automatic issue(logic [31:0] ta, logic [31:0] tb, logic tc, logic ts,
                             logic [31:0] es, logic eco, logic eov);
            int k = 0;
            @(posedge clk);
            #1;
            a = W'(ta);
            b = W'(tb);
            cin = tc;
            sub = ts;
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL w%0d accept_timeout: in_ready=%b required 1", W, in_ready);
            end else begin
                push_exp(es, eco, eov);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        // Wait, with a bound, until every expected result has been consumed.
        task automatic drain(output int nbusy);
            int k = 0;
            nbusy = 0;
            while (q.size() > 0 && k < 200) begin
                @(negedge clk);
                if (busy) nbusy++;
                k++;
            end
            if (q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL w%0d drain_timeout: pending=%0d required 0", W, q.size());
            end
        endtask

        // Monitor: check latency on the first cycle of out_valid, check the result on the handshake.
        always @(negedge clk) begin
            exp_t e;
            if (rst_n_l && out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL w%0d unexpected_result: sum=%0h with nothing outstanding", W, sum);
                    end else begin
                        check($sformatf("w%0d_latency", W), 64'(edge_cnt - q[0].acc), 64'(N));
                    end
                end
                if (out_ready) begin
                    seen = 1'b0;
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check($sformatf("w%0d_sum", W), 64'(sum), 64'(e.s));
                        check($sformatf("w%0d_cout", W), 64'(cout), 64'(e.co));
                        check($sformatf("w%0d_ovf", W), 64'(ovf), 64'(e.ov));
                    end
                end
            end
        end

        if (g == 0) begin : g_dir
            // Directed cases at WIDTH=16.
            initial begin
                int nb;
                rst_n_l = 1'b0;
                in_valid = 1'b0;
                a = '0;
                b = '0;
                cin = 1'b0;
                sub = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                check("reset_in_ready", 64'(in_ready), 64'd1);
                check("reset_out_valid", 64'(out_valid), 64'd0);
                check("reset_busy", 64'(busy), 64'd0);
                check("reset_sum", 64'(sum), 64'd0);
                check("reset_cout_ovf", 64'({cout, ovf}), 64'd0);
                @(posedge clk);
                #1;
                rst_n_l = 1'b1;

                issue(32'h1234, 32'h0FFF, 1'b0, 1'b0, 32'h2233, 1'b0, 1'b0);
                drain(nb);
                check("busy_cycles", 64'(nb), 64'd4);
                issue(32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
                drain(nb);
                issue(32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
                drain(nb);
                issue(32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0);
                drain(nb);
                issue(32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
                drain(nb);
                issue(32'h8000, 32'h0001, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1);
                drain(nb);
                check("busy_cycles_sub", 64'(nb), 64'd4);

                // Backpressure, with in_valid and new operands held during RUN and DONE.
                out_ready = 1'b0;
                issue(32'h1234, 32'h0FFF, 1'b0, 1'b0, 32'h2233, 1'b0, 1'b0);
                a = 16'hAAAA;
                b = 16'h5555;
                sub = 1'b1;
                in_valid = 1'b1;
                begin
                    int k = 0;
                    @(negedge clk);
                    while (!out_valid && k < 20) begin
                        check("bp_run_in_ready", 64'(in_ready), 64'd0);
                        @(negedge clk);
                        k++;
                    end
                end
                check("bp_done_reached", 64'(out_valid), 64'd1);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    a = 16'($urandom);
                    b = 16'($urandom);
                    cin = 1'($urandom);
                    @(negedge clk);
                    check("bp_hold_valid", 64'(out_valid), 64'd1);
                    check("bp_hold_in_ready", 64'(in_ready), 64'd0);
                    check("bp_hold_sum", 64'(sum), 64'h2233);
                    check("bp_hold_cout_ovf", 64'({cout, ovf}), 64'd0);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("bp_idle_in_ready", 64'(in_ready), 64'd1);
                check("bp_idle_out_valid", 64'(out_valid), 64'd0);
                repeat (6) @(negedge clk);
                check("bp_no_capture", 64'(out_valid | busy), 64'd0);
                check("bp_queue_empty", 64'(q.size()), 64'd0);

                // Asynchronous reset during the second RUN cycle.
                @(posedge clk);
                #1;
                a = 16'h1234;
                b = 16'h0FFF;
                cin = 1'b0;
                sub = 1'b0;
                in_valid = 1'b1;
                @(negedge clk);
                check("rst_accept_ready", 64'(in_ready), 64'd1);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                @(posedge clk);
                #2;
                check("rst_pre_busy", 64'(busy), 64'd1);
                rst_n_l = 1'b0;
                #1;
                check("rst_async_busy", 64'(busy), 64'd0);
                check("rst_async_out_valid", 64'(out_valid), 64'd0);
                check("rst_async_in_ready", 64'(in_ready), 64'd1);
                check("rst_async_sum", 64'(sum), 64'd0);
                check("rst_async_cout_ovf", 64'({cout, ovf}), 64'd0);
                @(posedge clk);
                #1;
                rst_n_l = 1'b1;
                issue(32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0);
                drain(nb);
                check("busy_cycles_after_rst", 64'(nb), 64'd4);
                r_done = 1'b1;
            end
        end else begin : g_rnd
            // Random sweep checked against the reference model.
            initial begin
                logic [31:0] ta, tb, es;
                logic        tc, ts, eco, eov;
                int          nb;
                rst_n_l = 1'b0;
                in_valid = 1'b0;
                a = '0;
                b = '0;
                cin = 1'b0;
                sub = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n_l = 1'b1;
                for (int k = 0; k < 1000; k++) begin
                    ta = $urandom;
                    tb = $urandom;
                    tc = 1'($urandom);
                    ts = 1'($urandom);
                    ref_model(W, ta, tb, tc, ts, es, eco, eov);
                    issue(ta, tb, tc, ts, es, eco, eov);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
                drain(nb);
                r_done = 1'b1;
            end

            initial begin
                out_ready = 1'b0;
                forever begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    initial begin
        int k = 0;
        while (!(g_inst[0].r_done && g_inst[1].r_done && g_inst[2].r_done) && k < 80000) begin
            @(posedge clk);
            k++;
        end
        if (!(g_inst[0].r_done && g_inst[1].r_done && g_inst[2].r_done)) begin
            total++;
            bad++;
            $display("FAIL global_timeout: done=%b%b%b required 111",
                     g_inst[2].r_done, g_inst[1].r_done, g_inst[0].r_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
